// File: rtl/isr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : isr_arbiter
// Brief    : Round-robin arbiter sharing one multi-cycle integer square root
//            unit among NUM_REQ requesters, with a hung-operation watchdog.
// Revision : 1.0
// ============================================================================
module isr_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 127
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [64*NUM_REQ-1:0] req_value,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           resp_result,
    output logic                  resp_error,
    output logic                  isr_reset,
    output logic [63:0]           isr_value,
    input  logic [31:0]           isr_result,
    input  logic                  isr_done,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t              r_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_id;
    logic [7:0]          r_wdog;
    logic [63:0]         r_isr_value;
    logic [31:0]         r_result;
    logic                r_error;
    logic                r_resp_valid;

    logic                w_found;
    logic [ID_W-1:0]     w_winner;
    int                  w_idx;
    logic [NUM_REQ-1:0]  w_grant;
    logic                w_transfer;
    logic [63:0]         w_sel_value;
    logic [ID_W-1:0]     w_next_ptr;
    logic                w_timeout;

    // Priority search starts at the round-robin pointer and wraps at NUM_REQ,
    // not at 2^ID_W, so non-power-of-two requester counts stay fair.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = ID_W'(w_idx);
            end
        end
    end

    assign w_transfer = (r_state == ST_IDLE) && w_found;

    always_comb begin
        w_grant = '0;
        if (w_transfer) begin
            w_grant[w_winner] = 1'b1;
        end
    end

    assign w_sel_value = req_value[int'(w_winner)*64 +: 64];
    assign w_next_ptr  = (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
    assign w_timeout   = (r_wdog == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= '0;
            r_id         <= '0;
            r_wdog       <= '0;
            r_isr_value  <= '0;
            r_result     <= '0;
            r_error      <= 1'b0;
            r_resp_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_transfer) begin
                        r_isr_value <= w_sel_value;
                        r_id        <= w_winner;
                        r_rr_ptr    <= w_next_ptr;
                        r_state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // A stale done from the previous operation is ignored here.
                    r_wdog  <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_wdog <= r_wdog + 8'd1;
                    if (isr_done) begin
                        r_result     <= isr_result;
                        r_error      <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end else if (w_timeout) begin
                        r_result     <= '0;
                        r_error      <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = w_grant;
    assign resp_valid  = r_resp_valid;
    assign resp_id     = r_id;
    assign resp_result = r_result;
    assign resp_error  = r_error;
    assign isr_value   = r_isr_value;
    // The unit is reset together with the arbiter as well as at each start.
    assign isr_reset   = reset | (r_state == ST_LOAD);
    assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/isr_arbiter.md
Name: isr_arbiter

Overview:
- Shares one multi-cycle integer square root unit (64-bit value in, 32-bit result out, done flag) among NUM_REQ requesters.
- Accepts requests with round-robin fairness and latches the winner's operand.
- Sequences the ISR by pulsing its synchronous reset, waits for done, and returns the tagged result over a valid/ready response channel.
- Includes a watchdog that aborts a hung computation.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must equal ceil(log2(NUM_REQ)).
- TIMEOUT_CYCLES, 127, maximum WAIT cycles before abort (1..255).

Ports:
- clock  in  1  system clock; everything is sampled on the posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_value  in  64*NUM_REQ  operands; requester i uses bits [64i+63:64i].
- req_ready  out  NUM_REQ  one-hot accept; a transfer occurs when req_valid[i] and req_ready[i] are both 1.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accept.
- resp_id  out  ID_W  requester index of the response.
- resp_result  out  32  square root result.
- resp_error  out  1  1 = watchdog timeout; resp_result is 0.
- isr_reset  out  1  reset/start pulse to the ISR.
- isr_value  out  64  operand to the ISR, held stable for the whole operation.
- isr_result  in  32  ISR result.
- isr_done  in  1  ISR completion flag.
- busy  out  1  high in LOAD, WAIT and RESP.

Behaviour:
- States: IDLE, LOAD, WAIT, RESP.
- Reset:
  - state goes to IDLE; rr_ptr=0; resp_valid=0; resp_error=0; resp_id=0; resp_result=0; isr_value=0; busy=0.
  - isr_reset = reset OR (state==LOAD), so the ISR is reset in the same cycle as the arbiter.
- Arbitration (combinational, IDLE only):
  - Winner is the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready is one-hot on the winner; req_ready=0 outside IDLE or when no request is valid.
  - Requesters hold req_valid and req_value until accepted.
- IDLE -> LOAD on a transfer. In that cycle: latch isr_value from the winner's req_value, latch the winner ID, set rr_ptr=(winner+1) mod NUM_REQ.
- LOAD (1 cycle):
  - isr_reset=1; isr_done is ignored.
  - Next state is WAIT; the watchdog counter clears to 0.
- WAIT:
  - isr_reset=0; the counter increments every cycle.
  - isr_done=1: capture isr_result into resp_result, set resp_error=0, go to RESP.
  - Otherwise, counter reaching TIMEOUT_CYCLES-1: set resp_result=0, resp_error=1, go to RESP.
  - If done and timeout occur in the same cycle, done wins (no error).
- RESP:
  - resp_valid=1; resp_id, resp_result and resp_error are held stable until resp_ready=1.
  - On acceptance go to IDLE; resp_valid drops the next cycle.
  - No new request is accepted before returning to IDLE, so there is at most one operation in flight.
- Latency:
  - Accept at edge k; isr_reset high during cycle k+1; WAIT from k+2.
  - resp_valid rises the cycle after isr_done is sampled high.
  - A new grant is possible at the earliest in the cycle after resp acceptance.
- isr_value does not change from LOAD through RESP, even if requesters change req_value.
- Reset mid-operation (any state):
  - Returns to IDLE next cycle; the in-flight result is discarded and resp_valid=0.
  - The ISR is reset via isr_reset.
  - rr_ptr returns to 0.
- NUM_REQ not a power of two: the priority search wraps at NUM_REQ, never at 2^ID_W.

Test Plan:
- Requester 2 only, value 121, resp_ready=1 -> req_ready=4'b0100 for one cycle; isr_reset pulse one cycle later; response id=2, result=11, error=0; busy low after acceptance.
- Requesters 0 and 1 request in the same cycle, values 0 and 64'hFFFF_FFFE_0000_0001 -> requester 0 served first with result 0, then requester 1 with result 32'hFFFF_FFFF; no overlap.
- All 4 requesters held valid continuously with random squares -> grant order 0,1,2,3,0,1; every result equals the square root of its operand.
- resp_ready held low for 10 cycles after resp_valid -> resp_valid, resp_id and resp_result stay constant; req_ready stays 0; acceptance on cycle 11 returns to IDLE.
- During WAIT, requester changes req_value; then reset asserted for 1 cycle in WAIT -> operand change has no effect on isr_value; after reset, state is IDLE, resp_valid=0, isr_reset=1 during the reset cycle; next request (value 144) returns 12.
- ISR stub with isr_done tied 0 -> resp_valid exactly TIMEOUT_CYCLES cycles after WAIT entry, resp_error=1, resp_result=0; a following request with a real ISR completes normally.
